// File: rtl/vector_fu_pkg.sv
// Shared types and constants for the vector functional unit: lane geometry,
// operation encoding, FSM states and config-word bit positions.
package vector_fu_pkg;

    localparam int WIDTH        = 16;
    localparam int NUM_INPUTS   = 4;
    localparam int TOTAL_INPUTS = NUM_INPUTS * 2;

    localparam int OP_LSB      = 0;
    localparam int OP_MSB      = 2;
    localparam int ACC_EN_BIT  = 3;
    localparam int ACC_CLR_BIT = 4;

    typedef logic [WIDTH-1:0] word_t;

    typedef enum logic [2:0] {
        OP_ADD    = 3'd0,
        OP_SUB    = 3'd1,
        OP_MUL    = 3'd2,
        OP_AND    = 3'd3,
        OP_OR     = 3'd4,
        OP_XOR    = 3'd5,
        OP_PASS_A = 3'd6,
        OP_MAX    = 3'd7
    } op_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CAPTURE  = 3'd1,
        EXEC     = 3'd2,
        SEND     = 3'd3,
        WAIT_ACK = 3'd4
    } fu_state_e;

endpackage

// File: rtl/vector_fu_if.sv
// Bus between the memory stage / neighbour tile (master) and the vector FU (slave):
// activation strobe, operand read bus, and the result write handshake.
interface vector_fu_if;
    import vector_fu_pkg::*;

    logic                          on_off_in;
    word_t [TOTAL_INPUTS:0]        r_data_in;
    logic                          write_en_out;
    logic                          write_rdy_in;
    word_t [NUM_INPUTS-1:0]        w_data_out;
    logic                          write_ack_in;
    logic                          busy;
    logic                          done;

    modport master (
        output on_off_in, r_data_in, write_rdy_in, write_ack_in,
        input  write_en_out, w_data_out, busy, done
    );

    modport slave (
        input  on_off_in, r_data_in, write_rdy_in, write_ack_in,
        output write_en_out, w_data_out, busy, done
    );

endinterface

// File: rtl/fu_lane.sv
// One lane of the vector FU: operation mux, a registered multiply stage, the
// result register, and the lane accumulator.
module fu_lane
    import vector_fu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  word_t a,
    input  word_t b,
    input  op_e   op,
    input  logic  acc_en,
    input  logic  acc_clr,
    input  logic  res_load,
    input  logic  acc_update,
    output word_t res
);

    word_t mul_q;
    word_t res_q;
    word_t acc_q;
    word_t op_val;
    word_t sum;

    // Select the lane operation and fold in the accumulator when enabled.
    always_comb begin
        op_val = '0;
        case (op)
            OP_ADD:    op_val = a + b;
            OP_SUB:    op_val = a - b;
            OP_MUL:    op_val = mul_q;
            OP_AND:    op_val = a & b;
            OP_OR:     op_val = a | b;
            OP_XOR:    op_val = a ^ b;
            OP_PASS_A: op_val = a;
            OP_MAX:    op_val = ($signed(a) > $signed(b)) ? a : b;
            default:   op_val = '0;
        endcase
        sum = op_val + (acc_en ? acc_q : '0);
    end

    // First multiply stage; operands are held stable by the top after capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) mul_q <= '0;
        else       mul_q <= word_t'(a * b);
    end

    // Result register, loaded once at the end of execution.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         res_q <= '0;
        else if (res_load) res_q <= sum;
    end

    // Accumulator: cleared at capture when requested, updated when the result is acknowledged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)           acc_q <= '0;
        else if (acc_clr)    acc_q <= '0;
        else if (acc_update) acc_q <= res_q;
    end

    assign res = res_q;

endmodule

// File: rtl/vector_fu.sv
// Vector functional unit top: activation edge detect, operand capture, the
// control FSM and the write handshake toward the neighbour tile.
module vector_fu
    import vector_fu_pkg::*;
(
    input logic        clk,
    input logic        reset,
    vector_fu_if.slave bus
);

    fu_state_e              state_q, state_d;
    logic                   on_off_q;
    logic                   write_en_q, write_en_d;
    logic                   done_q, done_d;
    logic                   mul_wait_q, mul_wait_d;
    word_t [NUM_INPUTS-1:0] a_q, b_q, lane_res;
    op_e                    op_q;
    logic                   acc_en_q;
    logic                   capture, res_load, acc_update, acc_clr;
    word_t                  cfg_word;
    logic                   unused_cfg;

    assign cfg_word   = bus.r_data_in[TOTAL_INPUTS];
    assign unused_cfg = ^cfg_word[WIDTH-1:ACC_CLR_BIT+1];
    assign acc_clr    = capture & cfg_word[ACC_CLR_BIT];

    // Next-state and control strobes; MUL spends one extra cycle in EXEC.
    always_comb begin
        state_d    = state_q;
        write_en_d = write_en_q;
        done_d     = 1'b0;
        mul_wait_d = 1'b0;
        capture    = 1'b0;
        res_load   = 1'b0;
        acc_update = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.on_off_in && !on_off_q) state_d = CAPTURE;
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                if (op_q == OP_MUL && !mul_wait_q) begin
                    mul_wait_d = 1'b1;
                end else begin
                    res_load = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (bus.write_rdy_in) begin
                    write_en_d = 1'b1;
                    state_d    = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (bus.write_ack_in) begin
                    write_en_d = 1'b0;
                    done_d     = 1'b1;
                    acc_update = acc_en_q;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, handshake outputs, edge detector and captured operands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            on_off_q   <= 1'b0;
            write_en_q <= 1'b0;
            done_q     <= 1'b0;
            mul_wait_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= OP_ADD;
            acc_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            on_off_q   <= bus.on_off_in;
            write_en_q <= write_en_d;
            done_q     <= done_d;
            mul_wait_q <= mul_wait_d;
            if (capture) begin
                a_q      <= bus.r_data_in[NUM_INPUTS-1:0];
                b_q      <= bus.r_data_in[TOTAL_INPUTS-1:NUM_INPUTS];
                op_q     <= op_e'(cfg_word[OP_MSB:OP_LSB]);
                acc_en_q <= cfg_word[ACC_EN_BIT];
            end
        end
    end

    for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_lane
        fu_lane u_lane (
            .clk        (clk),
            .reset      (reset),
            .a          (a_q[i]),
            .b          (b_q[i]),
            .op         (op_q),
            .acc_en     (acc_en_q),
            .acc_clr    (acc_clr),
            .res_load   (res_load),
            .acc_update (acc_update),
            .res        (lane_res[i])
        );
    end

    assign bus.write_en_out = write_en_q;
    assign bus.w_data_out   = lane_res;
    assign bus.busy         = (state_q != IDLE);
    assign bus.done         = done_q;

endmodule
